// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multiport register file
package regfile_pkg;

  // Register 0 is hardwired: never written, never busy, always reads as zero.
  localparam int ZERO_REG = 0;

  // Ceiling log2 usable in parameter expressions; loop bound keeps it elaboration-friendly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Bit offset of field k inside a packed multi-port bus of w-bit fields.
  function automatic int port_offset(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for RAW hazard detection
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic              wr0_release,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic              wr1_release,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic              busy_any
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // Next busy state: a claim supersedes any same-cycle release of that register.
  always_comb begin
    busy_next = busy;
    busy_next[ZERO_REG] = 1'b0;
    for (int r = 1; r < DEPTH; r++) begin
      if (claim_en && claim_addr == AW'(r)) begin
        busy_next[r] = 1'b1;
      end else if ((wr0_en && wr0_release && wr0_addr == AW'(r)) ||
                   (wr1_en && wr1_release && wr1_addr == AW'(r))) begin
        busy_next[r] = 1'b0;
      end
    end
  end

  // Busy vector register, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Lookups see registered state only; releases are not forwarded.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = busy[rd_addr[port_offset(k, AW) +: AW]];
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - two-write, NRD-read register file with bypass and scoreboard
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_addr,
  input  logic [WIDTH-1:0]     wr0_data,
  input  logic                 wr0_release,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_addr,
  input  logic [WIDTH-1:0]     wr1_data,
  input  logic                 wr1_release,
  input  logic                 claim_en,
  input  logic [AW-1:0]        claim_addr,
  output logic                 busy_any
);

  // Flop array rather than RAM so reset can clear every entry in one edge.
  logic [WIDTH-1:0] mem [DEPTH];

  // Commit writes; port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      if (wr0_en && wr0_addr != AW'(ZERO_REG)) mem[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != AW'(ZERO_REG)) mem[wr1_addr] <= wr1_data;
    end
  end

  // Combinational read ports with optional same-cycle forwarding of write data.
  always_comb begin
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    a = '0;
    d = '0;
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[port_offset(k, AW) +: AW];
      d = mem[a];
      if (BYPASS != 0 && !reset) begin
        if (wr1_en && wr1_addr == a)      d = wr1_data;
        else if (wr0_en && wr0_addr == a) d = wr0_data;
      end
      if (a == AW'(ZERO_REG)) d = '0;
      rd_data[port_offset(k, WIDTH) +: WIDTH] = d;
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_release (wr0_release),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_release (wr1_release),
    .claim_en    (claim_en),
    .claim_addr  (claim_addr),
    .busy_any    (busy_any)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] rd_addr;
  logic        wr0_en, wr0_release, wr1_en, wr1_release, claim_en;
  logic [4:0]  wr0_addr, wr1_addr, claim_addr;
  logic [31:0] wr0_data, wr1_data;

  logic [127:0] rd_data_b1;
  logic [3:0]   rd_busy_b1;
  logic         busy_any_b1;
  logic [63:0]  rd_data_b0;
  logic [1:0]   rd_busy_b0;
  logic         busy_any_b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.WIDTH(32), .DEPTH(32), .NRD(4), .BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b1), .rd_busy(rd_busy_b1),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_release(wr0_release),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_release(wr1_release),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any_b1)
  );

  regfile_multiport #(.WIDTH(32), .DEPTH(32), .NRD(2), .BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr[9:0]), .rd_data(rd_data_b0), .rd_busy(rd_busy_b0),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_release(wr0_release),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_release(wr1_release),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any_b0)
  );

  // Reference model: architectural register values and busy flags.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          model_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bypass);
    if (a == 5'd0) return 32'h0;
    if (bypass && !reset) begin
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
    end
    return m_mem[a];
  endfunction

  function automatic bit exp_any();
    bit any;
    any = 1'b0;
    for (int r = 0; r < 32; r++) any |= m_busy[r];
    return any;
  endfunction

  // Advance the model at each clock edge from the architectural rules.
  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  <= 32'h0;
        m_busy[r] <= 1'b0;
      end
      model_valid <= 1'b1;
    end else begin
      if (wr1_en && wr1_addr != 5'd0) m_mem[wr1_addr] <= wr1_data;
      if (wr0_en && wr0_addr != 5'd0 && !(wr1_en && wr1_addr == wr0_addr))
        m_mem[wr0_addr] <= wr0_data;
      for (int r = 1; r < 32; r++) begin
        if (claim_en && claim_addr == 5'(r))
          m_busy[r] <= 1'b1;
        else if ((wr0_en && wr0_release && wr0_addr == 5'(r)) ||
                 (wr1_en && wr1_release && wr1_addr == 5'(r)))
          m_busy[r] <= 1'b0;
      end
    end
  end

  // Compare every meaningful cycle, mid-period.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b1_rd_data%0d", k), rd_data_b1[k*32 +: 32], exp_read(rd_addr[k*5 +: 5], 1'b1));
        check($sformatf("b1_rd_busy%0d", k), 32'(rd_busy_b1[k]), 32'(m_busy[rd_addr[k*5 +: 5]]));
      end
      for (int k = 0; k < 2; k++) begin
        check($sformatf("b0_rd_data%0d", k), rd_data_b0[k*32 +: 32], exp_read(rd_addr[k*5 +: 5], 1'b0));
        check($sformatf("b0_rd_busy%0d", k), 32'(rd_busy_b0[k]), 32'(m_busy[rd_addr[k*5 +: 5]]));
      end
      check("b1_busy_any", 32'(busy_any_b1), 32'(exp_any()));
      check("b0_busy_any", 32'(busy_any_b0), 32'(exp_any()));
    end
  end

  task automatic idle();
    reset = 1'b0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_release = 1'b0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_release = 1'b0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rd_addr = '0;

    // Reset with a conflicting write that must be ignored.
    reset = 1'b1; wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    next_cycle();
    idle(); rd_addr = {5'd5, 5'd5, 5'd5, 5'd5};
    @(negedge clk);
    check("rst_r5", rd_data_b1[31:0], 32'h0);
    check("rst_busy_any", 32'(busy_any_b1), 32'h0);

    // Same-address collision, then disjoint dual write.
    next_cycle();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222;
    next_cycle();
    idle(); rd_addr = {5'd0, 5'd0, 5'd7, 5'd7};
    @(negedge clk);
    check("collide_b1", rd_data_b1[31:0], 32'h22222222);
    check("collide_b0", rd_data_b0[63:32], 32'h22222222);
    next_cycle();
    wr0_en = 1'b1; wr0_addr = 5'd8; wr0_data = 32'h88888888;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h99999999;
    next_cycle();
    idle(); rd_addr = {5'd0, 5'd0, 5'd9, 5'd8};
    @(negedge clk);
    check("dual_r8", rd_data_b0[31:0], 32'h88888888);
    check("dual_r9", rd_data_b0[63:32], 32'h99999999);

    // Bypass versus stored-only read of r3.
    next_cycle();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h0000ABCD; rd_addr = {5'd0, 5'd0, 5'd0, 5'd3};
    @(negedge clk);
    check("bypass_same", rd_data_b1[31:0], 32'h0000ABCD);
    check("nobypass_same", rd_data_b0[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("nobypass_next", rd_data_b0[31:0], 32'h0000ABCD);

    // Register zero: writes and claim are discarded.
    next_cycle();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    claim_en = 1'b1; claim_addr = 5'd0; rd_addr = '0;
    @(negedge clk);
    check("r0_bypass", rd_data_b1[31:0], 32'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("r0_data", rd_data_b1[63:32], 32'h0);
    check("r0_busy", 32'(rd_busy_b1), 32'h0);
    check("r0_busy_any", 32'(busy_any_b1), 32'h0);

    // Scoreboard: claim, claim-vs-release race, plain release.
    next_cycle();
    claim_en = 1'b1; claim_addr = 5'd4; rd_addr = {5'd0, 5'd0, 5'd0, 5'd4};
    next_cycle();
    idle();
    @(negedge clk);
    check("claim_busy", 32'(rd_busy_b1[0]), 32'h1);
    check("claim_any", 32'(busy_any_b1), 32'h1);
    next_cycle();
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h44444444; wr1_release = 1'b1;
    claim_en = 1'b1; claim_addr = 5'd4;
    next_cycle();
    idle();
    @(negedge clk);
    check("race_busy", 32'(rd_busy_b1[0]), 32'h1);
    check("race_data", rd_data_b0[31:0], 32'h44444444);
    next_cycle();
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h45454545; wr1_release = 1'b1;
    @(negedge clk);
    check("rel_not_bypassed", 32'(rd_busy_b1[0]), 32'h1);
    next_cycle();
    idle();
    @(negedge clk);
    check("rel_busy", 32'(rd_busy_b1[0]), 32'h0);
    check("rel_any", 32'(busy_any_b1), 32'h0);
    check("rel_data", rd_data_b1[31:0], 32'h45454545);

    // Release without a write enable has no effect.
    next_cycle();
    claim_en = 1'b1; claim_addr = 5'd6; rd_addr = {5'd0, 5'd0, 5'd0, 5'd6};
    next_cycle();
    idle(); wr0_release = 1'b1; wr0_addr = 5'd6;
    next_cycle();
    idle();
    @(negedge clk);
    check("rel_no_en", 32'(rd_busy_b1[0]), 32'h1);

    // Randomised traffic with occasional reset pulses.
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      reset       = ($urandom_range(0, 199) == 0);
      wr0_en      = $urandom_range(0, 1);
      wr0_addr    = 5'($urandom_range(0, 15));
      wr0_data    = $urandom;
      wr0_release = $urandom_range(0, 1);
      wr1_en      = $urandom_range(0, 1);
      wr1_addr    = 5'($urandom_range(0, 15));
      wr1_data    = $urandom;
      wr1_release = $urandom_range(0, 1);
      claim_en    = ($urandom_range(0, 9) < 3);
      claim_addr  = 5'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) rd_addr[k*5 +: 5] = 5'($urandom_range(0, 15));
    end
    next_cycle();
    idle();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
